// File: rtl/vga_frame_streamer.sv
// Streams a SRC_W x SRC_H RGB444 frame from a 1-cycle-latency BRAM as a 2^SCALE_SHIFT upscaled
// packet stream with sop/eop tags and a per-frame colour filter, through a credit-managed prefetch FIFO.
module vga_frame_streamer #(
    parameter int unsigned SRC_W       = 320,
    parameter int unsigned SRC_H       = 240,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        filter_mode,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [11:0]       rd_data,
    output logic [11:0]       out_data,
    output logic              start_p,
    output logic              end_p,
    output logic              out_valid,
    input  logic              vga_ready,
    output logic              underflow
);

    localparam int unsigned OUT_W = SRC_W << SCALE_SHIFT;
    localparam int unsigned OUT_H = SRC_H << SCALE_SHIFT;
    localparam int unsigned X_W   = $clog2(OUT_W);
    localparam int unsigned Y_W   = $clog2(OUT_H);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 2;

    localparam logic [X_W-1:0] X_LAST = X_W'(OUT_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(OUT_H - 1);
    localparam logic [Y_W-1:0] Y_REP  = Y_W'((1 << SCALE_SHIFT) - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [11:0] pix;
    } entry_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          mode_q, mode_d;

    logic                sop1_q, eop1_q, sop2_q, eop2_q, vld_q;
    logic [1:0]          mode1_q, mode2_q;

    entry_t              fifo_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                issue_c, first_c, last_c, credit_c, pop_c, empty_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [OCC_W-1:0]    occ_c, lim_c;
    entry_t              head_c;

    function automatic logic [11:0] apply_filter(input logic [1:0] mode, input logic [11:0] pix);
        logic [7:0] luma;
        logic [11:0] res;
        luma = 8'(5 * pix[11:8]) + 8'(9 * pix[7:4]) + 8'(2 * pix[3:0]);
        case (mode)
            2'd1:    res = {luma[7:4], luma[7:4], luma[7:4]};
            2'd2:    res = ~pix;
            default: res = pix;
        endcase
        return res;
    endfunction

    assign empty_c  = (cnt_q == '0);
    assign pop_c    = vga_ready & ~empty_c;
    assign first_c  = (x_q == '0) && (y_q == '0);
    assign last_c   = (x_q == X_LAST) && (y_q == Y_LAST);
    assign addr_c   = base_q + ADDR_W'(x_q >> SCALE_SHIFT);

    // Everything already committed (stored + both read stages) must fit once this cycle's pop leaves.
    assign occ_c    = OCC_W'(cnt_q) + OCC_W'(rd_en) + OCC_W'(vld_q);
    assign lim_c    = OCC_W'(DEPTH) + OCC_W'(pop_c);
    assign credit_c = (occ_c < lim_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        mode_d  = mode_q;
        issue_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && credit_c) begin
                    issue_c = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                issue_c = credit_c;
            end
            default: state_d = IDLE;
        endcase

        if (issue_c) begin
            if (first_c) begin
                mode_d = filter_mode;
            end
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d    = '0;
                    base_d = '0;
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end else begin
                    y_d = y_q + 1'b1;
                    // Source line advances only after its last replicated output line.
                    if ((y_q & Y_REP) == Y_REP) begin
                        base_d = base_q + ADDR_W'(SRC_W);
                    end
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Read issue stage and BRAM return stage, carrying tags and the frame's filter mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            sop1_q  <= 1'b0;
            eop1_q  <= 1'b0;
            mode1_q <= '0;
            vld_q   <= 1'b0;
            sop2_q  <= 1'b0;
            eop2_q  <= 1'b0;
            mode2_q <= '0;
        end else begin
            rd_en <= issue_c;
            if (issue_c) begin
                rd_addr <= addr_c;
                sop1_q  <= first_c;
                eop1_q  <= last_c;
                mode1_q <= mode_d;
            end
            vld_q   <= rd_en;
            sop2_q  <= sop1_q;
            eop2_q  <= eop1_q;
            mode2_q <= mode1_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            underflow <= 1'b0;
        end else begin
            if (vld_q) begin
                fifo_q[wr_ptr_q] <= '{sop: sop2_q, eop: eop2_q, pix: apply_filter(mode2_q, rd_data)};
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(vld_q) - CNT_W'(pop_c);
            if (vga_ready && empty_c) begin
                underflow <= 1'b1;
            end
        end
    end

    assign head_c    = fifo_q[rd_ptr_q];
    assign out_valid = ~empty_c;
    assign out_data  = empty_c ? 12'h000 : head_c.pix;
    assign start_p   = ~empty_c & head_c.sop;
    assign end_p     = ~empty_c & head_c.eop;

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Scoreboard bench for vga_frame_streamer on a reduced 16x8 source frame (32x16 output).
module tb_vga_frame_streamer;

    localparam int unsigned SRC_W  = 16;
    localparam int unsigned SRC_H  = 8;
    localparam int unsigned SS     = 1;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 17;
    localparam int OUT_W = SRC_W << SS;
    localparam int OUT_H = SRC_H << SS;
    localparam int NPIX  = OUT_W * OUT_H;
    localparam int LIMIT = 8000;

    typedef struct packed {
        logic [11:0] d;
        logic        s;
        logic        e;
    } pix_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [1:0]        filter_mode;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [11:0]       rd_data;
    logic [11:0]       out_data;
    logic              start_p;
    logic              end_p;
    logic              out_valid;
    logic              vga_ready;
    logic              underflow;

    logic [11:0] bram_q;
    logic        use_const;
    logic [11:0] cval;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int   pix_cnt = 0, iss_cnt = 0, max_occ = 0, dirty = 0, bubbles = 0;
    int   sop_cnt = 0, eop_cnt = 0, last_eop_rel = -1, frame_base = 0;
    bit   in_frame = 0;
    logic [11:0] rx [NPIX];

    vga_frame_streamer #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE_SHIFT(SS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .filter_mode(filter_mode),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .out_data(out_data), .start_p(start_p), .end_p(end_p), .out_valid(out_valid),
        .vga_ready(vga_ready), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) bram_q <= use_const ? cval : rd_addr[11:0];
    assign rd_data = bram_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_filter(input logic [1:0] m, input logic [11:0] d);
        int yv;
        logic [3:0] y4;
        yv = (5 * int'(d[11:8]) + 9 * int'(d[7:4]) + 2 * int'(d[3:0])) / 16;
        y4 = 4'(yv);
        if (m == 2'd1) return {y4, y4, y4};
        if (m == 2'd2) return 12'hFFF ^ d;
        return d;
    endfunction

    task automatic push_frame(input logic [1:0] m);
        pix_t p;
        int a;
        for (int y = 0; y < OUT_H; y++) begin
            for (int x = 0; x < OUT_W; x++) begin
                a   = (y >> SS) * int'(SRC_W) + (x >> SS);
                p.d = model_filter(m, use_const ? cval : 12'(a));
                p.s = (x == 0) && (y == 0);
                p.e = (x == OUT_W - 1) && (y == OUT_H - 1);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle enable pulse: exactly one frame is started from IDLE.
    task automatic start_frame(input logic [1:0] m);
        filter_mode = m;
        push_frame(m);
        frame_base = pix_cnt;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // Drives vga_ready until the given number of frame pixels are consumed (or the queue drains).
    task automatic run(input bit rnd, input int upto);
        int n = 0;
        while (exp_q.size() != 0 && (pix_cnt - frame_base) < upto && n < LIMIT) begin
            vga_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        vga_ready = 1'b0;
        if (n >= LIMIT) chk("timeout", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic do_reset();
        vga_ready = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        exp_q.delete();
        reset = 1'b1;
        tick();
    endtask

    // Output monitor: scoreboard pops, tag counting, occupancy and empty-output tracking.
    always @(negedge clk) begin
        pix_t e;
        int rel;
        if (!reset) begin
            iss_cnt  = pix_cnt;
            in_frame = 0;
        end else begin
            if (rd_en) iss_cnt++;
            if (iss_cnt - pix_cnt > max_occ) max_occ = iss_cnt - pix_cnt;
            if (!out_valid && (out_data != 12'h000 || start_p || end_p)) dirty++;
            if (in_frame && !out_valid) bubbles++;
            if (out_valid && vga_ready) begin
                rel = pix_cnt - frame_base;
                if (rel >= 0 && rel < NPIX) rx[rel] = out_data;
                if (start_p) begin sop_cnt++; in_frame = 1; end
                if (end_p) begin eop_cnt++; last_eop_rel = rel; in_frame = 0; end
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", {20'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("px_data", {20'h0, out_data}, {20'h0, e.d});
                    chk("px_sop", {31'h0, start_p}, {31'h0, e.s});
                    chk("px_eop", {31'h0, end_p}, {31'h0, e.e});
                end
                pix_cnt++;
            end
        end
    end

    initial begin
        int s0, e0, b0, n_rd;
        int addrs [4];
        logic ov [3];

        reset = 1'b0; enable = 1'b0; filter_mode = 2'd0; vga_ready = 1'b0;
        use_const = 1'b0; cval = 12'h000;
        tick(); tick();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_start", {31'h0, start_p}, 32'h0);
        chk("rst_end", {31'h0, end_p}, 32'h0);
        chk("rst_data", {20'h0, out_data}, 32'h0);
        chk("rst_rden", {31'h0, rd_en}, 32'h0);
        chk("rst_underflow", {31'h0, underflow}, 32'h0);
        reset = 1'b1;
        tick();

        // Prefetch fill with the consumer stalled.
        start_frame(2'd0);
        n_rd = 0;
        for (int k = 0; k < 4; k++) addrs[k] = -1;
        for (int k = 0; k < 10; k++) begin
            if (k < 3) ov[k] = out_valid;
            if (rd_en) begin
                if (n_rd < 4) addrs[n_rd] = int'(rd_addr);
                n_rd++;
            end
            tick();
        end
        chk("fill_reads", 32'(n_rd), 32'(DEPTH));
        chk("fill_addr0", 32'(addrs[0]), 32'd0);
        chk("fill_addr1", 32'(addrs[1]), 32'd0);
        chk("fill_addr2", 32'(addrs[2]), 32'd1);
        chk("fill_addr3", 32'(addrs[3]), 32'd1);
        chk("lat_not_yet", {31'h0, ov[1]}, 32'h0);
        chk("lat_head", {31'h0, ov[2]}, 32'h1);
        chk("fill_valid", {31'h0, out_valid}, 32'h1);
        chk("fill_start", {31'h0, start_p}, 32'h1);
        chk("fill_underflow", {31'h0, underflow}, 32'h0);

        // Full frame with continuous ready.
        s0 = sop_cnt; e0 = eop_cnt; b0 = bubbles;
        run(1'b0, NPIX);
        chk("full_drained", 32'(exp_q.size()), 32'd0);
        chk("px_x5_y3", {20'h0, rx[3 * OUT_W + 5]}, 32'd18);
        chk("sop_once", 32'(sop_cnt - s0), 32'd1);
        chk("eop_once", 32'(eop_cnt - e0), 32'd1);
        chk("eop_index", 32'(last_eop_rel), 32'(NPIX - 1));
        chk("no_bubbles", 32'(bubbles - b0), 32'd0);
        chk("full_underflow", {31'h0, underflow}, 32'h0);
        tick(); tick();

        // Greyscale, with a mid-frame mode change that must not take effect.
        use_const = 1'b1; cval = 12'hF80;
        start_frame(2'd1);
        run(1'b0, 50);
        filter_mode = 2'd2;
        run(1'b0, NPIX);
        chk("grey_first", {20'h0, rx[0]}, 32'h999);
        chk("grey_last", {20'h0, rx[NPIX - 1]}, 32'h999);
        tick(); tick();

        // Invert.
        cval = 12'h1A5;
        start_frame(2'd2);
        run(1'b0, NPIX);
        chk("invert_first", {20'h0, rx[0]}, 32'hE5A);
        tick(); tick();

        // Random ready: same sequence, bounded occupancy.
        use_const = 1'b0;
        max_occ = 0;
        start_frame(2'd0);
        run(1'b1, NPIX);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("occ_bound", {31'h0, max_occ <= int'(DEPTH)}, 32'h1);
        chk("empty_outputs_zero", 32'(dirty), 32'd0);
        tick(); tick();

        // Ready high before any data: sticky underflow, sop still delivered.
        do_reset();
        s0 = sop_cnt;
        vga_ready = 1'b1;
        start_frame(2'd0);
        run(1'b0, NPIX);
        chk("uf_set", {31'h0, underflow}, 32'h1);
        tick(); tick(); tick();
        chk("uf_sticky", {31'h0, underflow}, 32'h1);
        chk("uf_sop", 32'(sop_cnt - s0), 32'd1);

        // Reset mid-frame: restart at address 0 with sop and no stale pixels.
        do_reset();
        start_frame(2'd0);
        run(1'b0, 300);
        do_reset();
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_uf", {31'h0, underflow}, 32'h0);
        s0 = sop_cnt;
        start_frame(2'd0);
        run(1'b0, NPIX);
        chk("restart_first", {20'h0, rx[0]}, 32'h0);
        chk("restart_sop", 32'(sop_cnt - s0), 32'd1);
        chk("restart_drained", 32'(exp_q.size()), 32'd0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
